adc_sample_read: RTL and testbench

- SPI master that reads the 2-channel, 12-bit serial ADC which digitises the memristor response current after each DAC pulse. It is the receive-side counterpart of the DAC pulse path.
- On `start` it runs one dummy frame to load the channel select. It then takes 2^n conversions at a programmed microsecond interval, and returns each sample, their sum and their average.
- It sits beside the DAC pulse generator under the measurement sequencer and shares `clk` (50 MHz) with it.

---
 rtl/adc_sample_read.sv | 196 +++++++++++++++++++
 tb/tb_adc_sample_read.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_sample_read.sv
// adc_sample_read: SPI master for a 2-channel 12-bit serial ADC.
// Each sequence sends one dummy frame to load the channel select. It then
// takes 2^num_log2 conversions spaced by `interval` us and reports each
// sample, the running sum and the average.
// Optional macro ADC_CHK_EN: compares the received channel-ID bit against
// the latched channel and raises a sticky err flag on mismatch.
module adc_sample_read #(
  parameter int CNT_1US   = 50,
  parameter int SCK_DIV   = 2,
  parameter int QUIET_CYC = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        chan,
  input  logic [2:0]  num_log2,
  input  logic [15:0] interval,
  output logic        cs_n,
  output logic        sck,
  output logic        sdi,
  input  logic        sdo,
  output logic [11:0] sample,
  output logic        sample_vld,
  output logic [18:0] sum,
  output logic [11:0] avg,
  output logic        busy,
  output logic        done,
  output logic        err
);

  typedef enum logic [2:0] {IDLE, DUMMY, QUIET, CONV, WAIT, FINISH} state_t;

  localparam logic [3:0]  HLIM = 4'(SCK_DIV - 1);
  localparam logic [7:0]  QLIM = 8'(QUIET_CYC - 1);
  localparam logic [15:0] ULIM = 16'(CNT_1US - 1);

  state_t      state;
  logic        chan_l, dsent;
  logic [2:0]  nl;
  logic [15:0] intv;
  logic [7:0]  cnt;
  logic [3:0]  hcnt;
  logic [4:0]  edges;
  logic [11:0] sreg;
  logic [7:0]  qcnt;
  logic [15:0] udiv, ucnt;
  logic [16:0] ucnt_n;
  logic        qok, iv_ok, launch, conv_launch;
  logic [18:0] avg_full;
  logic [7:0]  tgt;

  // qcnt counts cycles since cs_n rose, so QLIM means the next fall lands
  // exactly QUIET_CYC cycles after the rise.
  assign qok    = qcnt >= QLIM;
  // Count the tick that happens on this edge so the fall lands on the tick.
  assign ucnt_n = {1'b0, ucnt} + 17'(udiv == ULIM);
  assign iv_ok  = ucnt_n >= {1'b0, intv};
  assign launch = ((state == DUMMY && !dsent) || state == QUIET ||
                   (state == WAIT && iv_ok)) && qok;
  assign conv_launch = launch && (state != DUMMY);
  assign avg_full = sum >> nl;
  assign tgt      = 8'd1 << nl;

`ifdef ADC_CHK_EN
  logic id_bit;
`else
  assign err = 1'b0;
`endif

  // Frame engine: cs_n/sck/sdi generation, sdo capture and quiet-gap counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cs_n  <= 1'b1;
      sck   <= 1'b1;
      sdi   <= 1'b0;
      hcnt  <= '0;
      edges <= '0;
      sreg  <= '0;
      qcnt  <= '0;
`ifdef ADC_CHK_EN
      id_bit <= 1'b0;
`endif
    end else if (launch) begin
      // sck stays high for the first cycle, then runs full low/high halves.
      cs_n  <= 1'b0;
      sck   <= 1'b1;
      sdi   <= chan_l;
      hcnt  <= HLIM;
      edges <= '0;
    end else if (!cs_n) begin
      if (hcnt == HLIM) begin
        hcnt <= '0;
        if (sck && edges == 5'd16) begin
          cs_n <= 1'b1;
          sdi  <= 1'b0;
          qcnt <= '0;
        end else begin
          sck <= ~sck;
          if (!sck) begin
            edges <= edges + 5'd1;
            sreg  <= {sreg[10:0], sdo};
`ifdef ADC_CHK_EN
            // Third rising edge carries word bit 13, the channel ID.
            if (edges == 5'd2) id_bit <= sdo;
`endif
          end else if (edges != 5'd0) begin
            // Control word is {chan, 15'b0}: after bit 15 only zeros follow.
            sdi <= 1'b0;
          end
        end
      end else begin
        hcnt <= hcnt + 4'd1;
      end
    end else if (qcnt != 8'hff) begin
      qcnt <= qcnt + 8'd1;
    end
  end

  // Interval timer: 1 us divider and us counter, restarted on each CONV fall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      udiv <= '0;
      ucnt <= '0;
    end else if (conv_launch) begin
      udiv <= '0;
      ucnt <= '0;
    end else if (udiv == ULIM) begin
      udiv <= '0;
      if (ucnt != 16'hffff) ucnt <= ucnt + 16'd1;
    end else begin
      udiv <= udiv + 16'd1;
    end
  end

  // Sequencer FSM with registered status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      sample_vld <= 1'b0;
      sample     <= '0;
      sum        <= '0;
      avg        <= '0;
      chan_l     <= 1'b0;
      nl         <= '0;
      intv       <= '0;
      cnt        <= '0;
      dsent      <= 1'b0;
`ifdef ADC_CHK_EN
      err        <= 1'b0;
`endif
    end else begin
      done       <= 1'b0;
      sample_vld <= 1'b0;
      case (state)
        IDLE: if (start && !busy && !done) begin
          chan_l <= chan;
          nl     <= num_log2;
          intv   <= interval;
          sum    <= '0;
          cnt    <= '0;
          dsent  <= 1'b0;
          busy   <= 1'b1;
          state  <= DUMMY;
`ifdef ADC_CHK_EN
          err    <= 1'b0;
`endif
        end
        // The dummy frame itself waits for the quiet gap after a prior frame.
        DUMMY: if (launch) dsent <= 1'b1;
               else if (dsent && cs_n) state <= QUIET;
        QUIET: if (launch) state <= CONV;
        CONV: if (cs_n) begin
          sample     <= sreg;
          sample_vld <= 1'b1;
          sum        <= sum + {7'b0, sreg};
          cnt        <= cnt + 8'd1;
          state      <= (cnt + 8'd1 == tgt) ? FINISH : WAIT;
`ifdef ADC_CHK_EN
          if (id_bit != chan_l) err <= 1'b1;
`endif
        end
        WAIT: if (launch) state <= CONV;
        FINISH: begin
          avg   <= avg_full[11:0];
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_adc_sample_read.sv
// Scoreboard bench for adc_sample_read: an ADC model serves queued words,
// a negedge monitor checks frames, samples and completion against queued
// hand-computed expectations.
module tb_adc_sample_read;

  logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0, chan = 1'b0, sdo = 1'b0;
  logic [2:0]  num_log2 = '0;
  logic [15:0] interval = '0;
  logic        cs_n, sck, sdi, sample_vld, busy, done, err;
  logic [11:0] sample, avg;
  logic [18:0] sum;

  adc_sample_read dut (
    .clk(clk), .rst_n(rst_n), .start(start), .chan(chan), .num_log2(num_log2),
    .interval(interval), .cs_n(cs_n), .sck(sck), .sdi(sdi), .sdo(sdo),
    .sample(sample), .sample_vld(sample_vld), .sum(sum), .avg(avg),
    .busy(busy), .done(done), .err(err)
  );

  always #10 clk = ~clk;

`ifdef ADC_CHK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  typedef struct {
    bit          kind;   // 0 = sample strobe, 1 = done strobe
    logic [11:0] smp;
    logic [18:0] sm;
    logic [11:0] av;
    logic        er;
  } exp_t;

  exp_t        exp_q[$];
  logic [15:0] words_q[$];
  longint      falls[$];
  int          nchk = 0, nfail = 0;
  longint      cyc = 0, vld_cyc = 0;
  int          vld_cnt = 0, win_cnt = 0;
  logic        exp_chan = 1'b0;

  task automatic chk(string nm, longint act, longint expv);
    nchk++;
    if (act != expv) begin
      nfail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, expv);
    end
  endtask

  function automatic logic [15:0] w(logic id, logic [11:0] d);
    return {2'b00, id, 1'b0, d};
  endfunction

  task automatic push_smp(logic [11:0] s, logic e);
    exp_t x;
    x.kind = 1'b0; x.smp = s; x.sm = '0; x.av = '0; x.er = e;
    exp_q.push_back(x);
  endtask

  task automatic push_done(logic [18:0] s, logic [11:0] a, logic e);
    exp_t x;
    x.kind = 1'b1; x.smp = '0; x.sm = s; x.av = a; x.er = e;
    exp_q.push_back(x);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // ADC model: loads a word at cs_n fall, shifts the next bit after each
  // sck rise, and records what it saw on DIN.
  logic [15:0] mw = '0, sdi_w = '0;
  int          bi = 0;
  logic        pcs = 1'b1, psck = 1'b1;
  always @(posedge clk) begin
    #1;
    if (pcs && !cs_n) begin
      mw = (words_q.size() != 0) ? words_q.pop_front() : 16'h0;
      bi = 15;
      sdo = mw[15];
      sdi_w = '0;
    end else if (!cs_n && !psck && sck) begin
      sdi_w = {sdi_w[14:0], sdi};
      bi--;
      if (bi >= 0) sdo = mw[bi];
    end
    pcs = cs_n;
    psck = sck;
  end

  // Monitor: frame shape plus scoreboard pops on sample_vld / done.
  logic wpcs = 1'b1, abort = 1'b0;
  int   len = 0;
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) abort = 1'b1;
    if (!cs_n) begin
      if (wpcs) begin len = 0; falls.push_back(cyc); abort = !rst_n; end
      len++;
    end else if (!wpcs && !abort) begin
      win_cnt++;
      chk("frame_len", len, 65);
      chk("sdi_word", sdi_w, {exp_chan, 15'b0});
    end
    wpcs = cs_n;
    if (rst_n && sample_vld) begin
      if (exp_q.size() == 0 || exp_q[0].kind) begin
        nchk++; nfail++;
        $display("FAIL unexpected_vld: got sample %0d expected no strobe", sample);
      end else begin
        e = exp_q.pop_front();
        chk("sample", sample, e.smp);
        chk("err_at_vld", err, e.er);
      end
      vld_cyc = cyc;
      vld_cnt++;
    end
    if (rst_n && done) begin
      if (exp_q.size() == 0 || !exp_q[0].kind) begin
        nchk++; nfail++;
        $display("FAIL unexpected_done: got done expected %0d pending", exp_q.size());
      end else begin
        e = exp_q.pop_front();
        chk("sum", sum, e.sm);
        chk("avg", avg, e.av);
        chk("err_at_done", err, e.er);
        chk("done_after_vld", cyc - vld_cyc, 1);
      end
    end
  end

  task automatic pulse_start(logic c, logic [2:0] n, logic [15:0] iv);
    @(posedge clk); #1;
    chan = c; num_log2 = n; interval = iv; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(string nm);
    int k = 0;
    do begin @(negedge clk); k++; end while (!done && k < 30000);
    if (!done) begin
      nchk++; nfail++;
      $display("FAIL %s_timeout: got no done expected done", nm);
    end
  endtask

  task automatic wait_vld(int target);
    int k = 0;
    do begin @(negedge clk); #1; k++; end while (vld_cnt < target && k < 30000);
    if (vld_cnt < target) begin
      nchk++; nfail++;
      $display("FAIL vld_timeout: got %0d expected %0d", vld_cnt, target);
    end
  endtask

  initial begin
    int w0, rises, k;
    logic ps;

    // Reset values
    repeat (3) @(negedge clk);
    chk("rst_cs_n", cs_n, 1); chk("rst_sck", sck, 1); chk("rst_sdi", sdi, 0);
    chk("rst_busy", busy, 0); chk("rst_done", done, 0); chk("rst_vld", sample_vld, 0);
    chk("rst_sum", sum, 0); chk("rst_avg", avg, 0); chk("rst_err", err, 0);
    @(posedge clk); #1 rst_n = 1'b1;

    // Single sample 0xABC
    exp_chan = 1'b0; w0 = win_cnt;
    words_q.push_back(w(0, 12'hABC)); words_q.push_back(w(0, 12'hABC));
    push_smp(12'hABC, 1'b0); push_done(19'hABC, 12'hABC, 1'b0);
    pulse_start(1'b0, 3'd0, 16'd0);
    chk("busy_after_start", busy, 1);
    wait_done("single");
    chk("single_windows", win_cnt - w0, 2);

    // Average of 4
    words_q.push_back(w(0, 12'd0));
    words_q.push_back(w(0, 12'd100)); words_q.push_back(w(0, 12'd200));
    words_q.push_back(w(0, 12'd300)); words_q.push_back(w(0, 12'd400));
    push_smp(12'd100, 1'b0); push_smp(12'd200, 1'b0);
    push_smp(12'd300, 1'b0); push_smp(12'd400, 1'b0);
    push_done(19'd1000, 12'd250, 1'b0);
    pulse_start(1'b0, 3'd2, 16'd0);
    wait_done("avg4");

    // Interval 10 us: CONV falls 500 clk apart
    falls.delete();
    words_q.push_back(w(0, 12'd0)); words_q.push_back(w(0, 12'd5)); words_q.push_back(w(0, 12'd7));
    push_smp(12'd5, 1'b0); push_smp(12'd7, 1'b0); push_done(19'd12, 12'd6, 1'b0);
    pulse_start(1'b0, 3'd1, 16'd10);
    wait_done("intv10");
    chk("intv10_falls", falls.size(), 3);
    if (falls.size() == 3) chk("intv10_spacing", falls[2] - falls[1], 500);

    // Interval 1 us is shorter than a frame: spacing is 65 + quiet gap
    falls.delete();
    words_q.push_back(w(0, 12'd0)); words_q.push_back(w(0, 12'd10)); words_q.push_back(w(0, 12'd20));
    push_smp(12'd10, 1'b0); push_smp(12'd20, 1'b0); push_done(19'd30, 12'd15, 1'b0);
    pulse_start(1'b0, 3'd1, 16'd1);
    wait_done("intv1");
    chk("intv1_falls", falls.size(), 3);
    if (falls.size() == 3) chk("intv1_spacing", falls[2] - falls[1], 69);

    // chan=1 with ADC reporting ID 0
    exp_chan = 1'b1;
    words_q.push_back(w(0, 12'd0)); words_q.push_back(w(0, 12'h123));
    push_smp(12'h123, CHK); push_done(19'h123, 12'h123, CHK);
    pulse_start(1'b1, 3'd0, 16'd0);
    wait_done("chan1");
    exp_chan = 1'b0;

    // Busy rules: mid-sequence start ignored, start in done cycle ignored,
    // start on the following cycle accepted
    words_q.push_back(w(0, 12'd0)); words_q.push_back(w(0, 12'd1000)); words_q.push_back(w(0, 12'd3000));
    push_smp(12'd1000, 1'b0); push_smp(12'd3000, 1'b0); push_done(19'd4000, 12'd2000, 1'b0);
    words_q.push_back(w(0, 12'd0)); words_q.push_back(w(0, 12'hFFF));
    push_smp(12'hFFF, 1'b0); push_done(19'd4095, 12'd4095, 1'b0);
    k = vld_cnt;
    pulse_start(1'b0, 3'd1, 16'd0);
    repeat (100) @(posedge clk);
    pulse_start(1'b1, 3'd3, 16'd5);
    wait_vld(k + 2);
    @(posedge clk); #1;
    chan = 1'b0; num_log2 = 3'd0; interval = 16'd0; start = 1'b1;
    @(negedge clk); chk("done_cycle", done, 1);
    @(posedge clk); #1;
    @(negedge clk); chk("start_at_done_ignored", busy, 0);
    @(posedge clk); #1 start = 1'b0;
    @(negedge clk); chk("start_after_done_busy", busy, 1);
    wait_done("restart");

    // Reset during the 8th sck period of a frame
    words_q.push_back(w(0, 12'd0));
    pulse_start(1'b0, 3'd0, 16'd0);
    rises = 0; ps = 1'b1; k = 0;
    while (!(rises == 7 && !sck) && k < 2000) begin
      @(negedge clk); k++;
      if (!cs_n && !ps && sck) rises++;
      ps = sck;
    end
    chk("reached_8th_period", rises, 7);
    #3 rst_n = 1'b0;
    #1;
    chk("abort_cs_n", cs_n, 1); chk("abort_sck", sck, 1);
    chk("abort_busy", busy, 0); chk("abort_sum", sum, 0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    words_q.delete();

    // Clean sequence after reset begins with a dummy frame
    w0 = win_cnt;
    words_q.push_back(w(0, 12'd0)); words_q.push_back(w(0, 12'h055));
    push_smp(12'h055, 1'b0); push_done(19'h055, 12'h055, 1'b0);
    pulse_start(1'b0, 3'd0, 16'd0);
    wait_done("post_reset");
    chk("post_reset_windows", win_cnt - w0, 2);

    repeat (5) @(negedge clk);
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
    $finish;
  end

endmodule
